// File: rtl/conv_window_gen.sv
// KxK sliding-window generator over a raster pixel stream, feeding a parallel-load FIFO.
// Optional CONV_WIN_STALL_CNT_EN adds o_stall_cnt, a saturating count of back-pressured cycles.
module conv_window_gen #(
    parameter int WIDTH = 8,
    parameter int K     = 3,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_win_valid,
    input  logic             i_win_ready,
    output logic [WIDTH-1:0] o_win [K*K],
    output logic             o_frame_done
`ifdef CONV_WIN_STALL_CNT_EN
    ,output logic [31:0]     o_stall_cnt
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [WIDTH-1:0] linebuf [K-1][IMG_W];
    logic [WIDTH-1:0] new_col [K];
    logic             accept;
    logic             col_last;
    logic             row_last;
    logic             win_done;
    logic             handoff;

    // Pixel handshake: a pixel moves on i_valid & o_ready. Window handshake: a window
    // moves on o_win_valid & i_win_ready; o_win is frozen while valid and not ready.
    assign o_ready  = (state != S_LAST) && (!o_win_valid || i_win_ready);
    assign accept   = i_valid && o_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign win_done = accept && (row >= RW'(K - 1)) && (col >= CW'(K - 1));
    assign handoff  = o_win_valid && i_win_ready;

    // Incoming column, oldest row on top.
    always_comb begin
        new_col[K-1] = i_data;
        for (int i = 0; i < K - 1; i++) begin
            new_col[i] = linebuf[K-2-i][col];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers carry no reset; the fill rows of every frame overwrite them.
    always_ff @(posedge i_clk) begin
        if (!i_rst && accept) begin
            for (int k = K - 2; k > 0; k--) begin
                linebuf[k][col] <= linebuf[k-1][col];
            end
            linebuf[0][col] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < K * K; n++) begin
                o_win[n] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    if (j < K - 1) begin
                        o_win[i*K+j] <= o_win[i*K+j+1];
                    end else begin
                        o_win[i*K+j] <= new_col[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_win_valid <= 1'b0;
        end else if (win_done) begin
            o_win_valid <= 1'b1;
        end else if (i_win_ready) begin
            o_win_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_FILL;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept && col_last && (row == RW'(K - 2))) state <= S_RUN;
                end
                S_RUN: begin
                    if (accept && col_last && row_last) state <= S_LAST;
                end
                S_LAST: begin
                    if (handoff) begin
                        o_frame_done <= 1'b1;
                        state        <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

`ifdef CONV_WIN_STALL_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
        end else if (o_win_valid && !i_win_ready && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 8x8 instance plus a 5x4 instance.
module tb_conv_window_gen;

    localparam int WIDTH = 8;
    localparam int K     = 3;
    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int NW    = K * K;
    localparam int PW    = WIDTH * NW;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             win_valid;
    logic             win_ready;
    logic [WIDTH-1:0] win [NW];
    logic             frame_done;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_win_valid;
    logic             s_win_ready;
    logic [WIDTH-1:0] s_win [NW];
    logic             s_frame_done;
`ifdef CONV_WIN_STALL_CNT_EN
    logic [31:0]      stall_cnt;
    logic [31:0]      s_stall_cnt;
`endif

    typedef struct {
        int          idx;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t          vecs [8];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            fd_cnt  = 0;
    int            s_fd_cnt = 0;
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] cap_q [$];
    logic [PW-1:0] s_exp_q [$];
    logic [PW-1:0] s_cap_q [$];
    logic [PW-1:0] mon_w;
    logic [PW-1:0] s_mon_w;

    conv_window_gen #(.WIDTH(WIDTH), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_data(data),
        .o_win_valid(win_valid), .i_win_ready(win_ready), .o_win(win),
        .o_frame_done(frame_done)
`ifdef CONV_WIN_STALL_CNT_EN
        , .o_stall_cnt(stall_cnt)
`endif
    );

    conv_window_gen #(.WIDTH(WIDTH), .K(K), .IMG_W(5), .IMG_H(4)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_ready), .i_data(s_data),
        .o_win_valid(s_win_valid), .i_win_ready(s_win_ready), .o_win(s_win),
        .o_frame_done(s_frame_done)
`ifdef CONV_WIN_STALL_CNT_EN
        , .o_stall_cnt(s_stall_cnt)
`endif
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] pack_win(input logic [WIDTH-1:0] w [NW]);
        logic [PW-1:0] res;
        for (int n = 0; n < NW; n++) res[n*WIDTH +: WIDTH] = w[n];
        return res;
    endfunction

    function automatic logic [PW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int            v [NW];
        logic [PW-1:0] res;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int n = 0; n < NW; n++) res[n*WIDTH +: WIDTH] = WIDTH'(v[n]);
        return res;
    endfunction

    // Reference window: pixel(r,c) = base + r*w + c, window completed at (r,c).
    function automatic logic [PW-1:0] model_win(input int base, input int w, input int r, input int c);
        logic [PW-1:0] res;
        int            p;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                p = base + (r - K + 1 + i) * w + (c - K + 1 + j);
                res[(i*K+j)*WIDTH +: WIDTH] = WIDTH'(p);
            end
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // scoreboard: every window handed off is compared against the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid && win_ready) begin
                mon_w = pack_win(win);
                cap_q.push_back(mon_w);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL win_extra: got %h want no window", mon_w);
                end else begin
                    check("win_seq", mon_w, exp_q.pop_front());
                end
            end
            if (frame_done) fd_cnt++;
            if (s_win_valid && s_win_ready) begin
                s_mon_w = pack_win(s_win);
                s_cap_q.push_back(s_mon_w);
                if (s_exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL s_win_extra: got %h want no window", s_mon_w);
                end else begin
                    check("s_win_seq", s_mon_w, s_exp_q.pop_front());
                end
            end
            if (s_frame_done) s_fd_cnt++;
        end
    end

    // driver: called #1 after a posedge, returns #1 after the accepting posedge
    task automatic drive_pixel(input int d, input int gaps);
        logic acc;
        int   budget;
        if (gaps > 0) begin
            valid = 1'b0;
            repeat (gaps) @(posedge clk);
            #1;
        end
        valid  = 1'b1;
        data   = WIDTH'(d);
        budget = 0;
        forever begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            #1;
            if (acc) break;
            budget++;
            if (budget > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL pixel_timeout: got no accept want accept of %0d", d);
                break;
            end
        end
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                drive_pixel(base + r * IMG_W + c, gaps ? int'($urandom_range(0, 2)) : 0);
        valid = 1'b0;
    endtask

    task automatic push_frame(input int base);
        for (int r = K - 1; r < IMG_H; r++)
            for (int c = K - 1; c < IMG_W; c++)
                exp_q.push_back(model_win(base, IMG_W, r, c));
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            fd0;
        int            c0;
        logic [PW-1:0] first;

        vecs[0] = '{0,  pack9(0, 1, 2, 8, 9, 10, 16, 17, 18)};
        vecs[1] = '{5,  pack9(5, 6, 7, 13, 14, 15, 21, 22, 23)};
        vecs[2] = '{9,  pack9(11, 12, 13, 19, 20, 21, 27, 28, 29)};
        vecs[3] = '{14, pack9(18, 19, 20, 26, 27, 28, 34, 35, 36)};
        vecs[4] = '{30, pack9(40, 41, 42, 48, 49, 50, 56, 57, 58)};
        vecs[5] = '{35, pack9(45, 46, 47, 53, 54, 55, 61, 62, 63)};
        vecs[6] = '{36, pack9(64, 65, 66, 72, 73, 74, 80, 81, 82)};
        vecs[7] = '{71, pack9(109, 110, 111, 117, 118, 119, 125, 126, 127)};
        first   = pack9(0, 1, 2, 8, 9, 10, 16, 17, 18);

        rst = 1'b1; valid = 1'b0; data = '0; win_ready = 1'b1;
        s_valid = 1'b0; s_data = '0; s_win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("rst_win_valid", int'(win_valid), 0);
        check_int("rst_ready", int'(ready), 1);
        check_int("rst_frame_done", int'(frame_done), 0);
        check("rst_win", pack_win(win), '0);
`ifdef CONV_WIN_STALL_CNT_EN
        check_int("rst_stall_cnt", int'(stall_cnt), 0);
`endif
        @(posedge clk);
        #1;

        // two frames back to back, full rate
        push_frame(0);
        push_frame(64);
        fd0 = fd_cnt;
        c0  = cyc;
        for (int p = 0; p < IMG_W * IMG_H; p++) drive_pixel(p, 0);
        check_int("throughput_cycles", cyc - c0, IMG_W * IMG_H);
        send_frame(64, 1'b0);
        settle();
        check_int("b2b_frame_done", fd_cnt - fd0, 2);
        check_int("b2b_pending", exp_q.size(), 0);
        check_int("b2b_win_count", cap_q.size(), 72);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("vec_%0d", vecs[i].idx), cap_q[vecs[i].idx], vecs[i].exp);
        end

        // back-pressure on the first window for 5 cycles
        cap_q.delete();
        push_frame(0);
        fd0 = fd_cnt;
        for (int p = 0; p <= 2 * IMG_W + 2; p++) drive_pixel(p, 0);
        win_ready = 1'b0;
        valid     = 1'b1;
        data      = WIDTH'(2 * IMG_W + 3);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check_int($sformatf("stall_valid_%0d", s), int'(win_valid), 1);
            check_int($sformatf("stall_ready_%0d", s), int'(ready), 0);
            check($sformatf("stall_win_%0d", s), pack_win(win), first);
            @(posedge clk);
            #1;
        end
`ifdef CONV_WIN_STALL_CNT_EN
        check_int("stall_cnt_5", int'(stall_cnt), 5);
`endif
        win_ready = 1'b1;
        for (int p = 2 * IMG_W + 3; p < IMG_W * IMG_H; p++) drive_pixel(p, 0);
        valid = 1'b0;
        settle();
        check_int("stall_frame_done", fd_cnt - fd0, 1);
        check_int("stall_pending", exp_q.size(), 0);
`ifdef CONV_WIN_STALL_CNT_EN
        check_int("stall_cnt_hold", int'(stall_cnt), 5);
`endif

        // random input gaps
        push_frame(0);
        fd0 = fd_cnt;
        send_frame(0, 1'b1);
        settle();
        check_int("gap_frame_done", fd_cnt - fd0, 1);
        check_int("gap_pending", exp_q.size(), 0);

        // reset right after pixel (3,4): its window is dropped
        for (int c = K - 1; c < IMG_W; c++) exp_q.push_back(model_win(0, IMG_W, 2, c));
        for (int c = K - 1; c < 4; c++) exp_q.push_back(model_win(0, IMG_W, 3, c));
        for (int p = 0; p <= 3 * IMG_W + 4; p++) drive_pixel(p, 0);
        rst   = 1'b1;
        valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_int("midrst_win_valid", int'(win_valid), 0);
        check_int("midrst_ready", int'(ready), 1);
        check_int("midrst_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
        push_frame(0);
        fd0 = fd_cnt;
        send_frame(0, 1'b0);
        settle();
        check_int("postrst_frame_done", fd_cnt - fd0, 1);
        check_int("postrst_pending", exp_q.size(), 0);

        // 5x4 frame on the small instance
        for (int r = K - 1; r < 4; r++)
            for (int c = K - 1; c < 5; c++)
                s_exp_q.push_back(model_win(0, 5, r, c));
        s_fd_cnt = 0;
        for (int p = 0; p < 20; p++) begin
            logic acc;
            int   budget;
            s_valid = 1'b1;
            s_data  = WIDTH'(p);
            budget  = 0;
            forever begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                if (acc) break;
                budget++;
                if (budget > 200) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL s_pixel_timeout: got no accept want accept of %0d", p);
                    break;
                end
            end
        end
        s_valid = 1'b0;
        settle();
        check_int("small_win_count", s_cap_q.size(), 6);
        check("small_first", s_cap_q[0], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
        check("small_last", s_cap_q[5], pack9(7, 8, 9, 12, 13, 14, 17, 18, 19));
        check_int("small_frame_done", s_fd_cnt, 1);
        check_int("small_pending", s_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
